regfile_wb_dump: RTL and testbench
==================================

Name: regfile_wb_dump

Overview:
- Parametrised successor of the datapath register bank.
- Holds NREGS general-purpose registers of XLEN bits with two combinational read ports.
- Writes back either the ALU result or memory load data, gated by two FSM write-back states.
- Optional same-cycle write-to-read bypass.
- A handshaked sequential dump engine streams every register to the testbench/debug side, replacing the flat per-register visualisation outputs.

Parameters:
- XLEN, 32, register data width.
- NREGS, 32, number of registers; power of two, >=2.
- AW, $clog2(NREGS), register index width (derived, not overridden).
- STATE_W, 4, width of the control-FSM state input.
- WB_STATE_A, 4'b0110, first state in which write-back is permitted.
- WB_STATE_B, 4'b0111, second state in which write-back is permitted.
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = read array only.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- estado  in  STATE_W  current control-FSM state.
- rs1  in  AW  read port 1 index.
- rs2  in  AW  read port 2 index.
- rd  in  AW  write index.
- regiwrite  in  1  register write enable.
- memtoreg  in  1  write source: 1 = reddataM, 0 = writedataR.
- writedataR  in  XLEN  ALU result.
- reddataM  in  XLEN  memory load data.
- readdata1R  out  XLEN  read port 1 data.
- readdata2R  out  XLEN  read port 2 data.
- dump_start  in  1  request a full register dump (pulse).
- dump_ready  in  1  consumer ready.
- dump_valid  out  1  dump_data/dump_idx valid.
- dump_idx  out  AW  index of the register presented.
- dump_data  out  XLEN  content of register dump_idx.
- dump_busy  out  1  dump engine active.
- dump_done  out  1  one-cycle pulse after the last transfer.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset:
  - All registers clear to 0.
  - Dump FSM returns to IDLE with dump_idx=0.
  - dump_valid, dump_busy and dump_done are 0.
  - No file preload.
- Write condition: (estado==WB_STATE_A || estado==WB_STATE_B) && regiwrite && rd!=0.
  - Data = memtoreg ? reddataM : writedataR.
  - Committed at the rising edge of clk.
  - Writes to index 0 are discarded; register 0 always reads 0.
- Reads: combinational, zero latency; rsX==0 yields 0.
  - BYPASS=1: if the write condition holds this cycle and rd==rsX, readdataXR returns the write data instead of the array value.
  - BYPASS=0: readdataXR returns the array value only; the new value is visible the cycle after the edge.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: dump_busy=0, dump_valid=0.
    - dump_start=1 -> SEND with dump_idx=0.
  - SEND: dump_busy=1, dump_valid=1.
    - dump_data = array[dump_idx], combinational; no bypass; register 0 shows 0.
    - A transfer occurs on a cycle with dump_valid && dump_ready.
    - If dump_idx<NREGS-1: increment dump_idx.
    - If dump_idx==NREGS-1: go to DONE.
    - dump_ready=0: hold dump_idx and dump_valid; dump_data follows live array content.
  - DONE: dump_done=1 for exactly one cycle, dump_busy=1, dump_valid=0 -> IDLE with dump_idx=0.
- dump_start is ignored outside IDLE; no queuing.
- Writes are fully permitted during a dump.
  - A write to the presented index in the transfer cycle: the consumer receives the pre-write value.
  - Later indices show post-write values.
- Reset asserted mid-dump: immediate return to IDLE, no dump_done pulse.
- Dump length is exactly NREGS transfers. Minimum duration from dump_start to dump_done is NREGS+1 cycles with dump_ready held at 1.

Test Plan:
1. Reset, then read rs1=5, rs2=31 -> both read 0; dump_valid=0, dump_busy=0.
2. estado=4'b0110, regiwrite=1, memtoreg=0, rd=3, writedataR=32'hDEADBEEF, rs1=3, BYPASS=1 -> readdata1R=32'hDEADBEEF in the same cycle. With BYPASS=0 -> 0 that cycle, 32'hDEADBEEF the next.
3. estado=4'b0111, memtoreg=1, rd=0, reddataM=32'h12345678 -> register 0 still reads 0. Same stimulus with estado=4'b0101, rd=4 -> register 4 unchanged.
4. Preload x1..x31 = index*4, pulse dump_start, dump_ready=1 -> 32 consecutive beats with dump_idx 0..31 and data 0,4,...,124, then dump_done high for one cycle, dump_busy low the following cycle.
5. During a dump, toggle dump_ready 1/0 on alternate cycles, and write rd=10=32'hCAFE at the cycle index 10 transfers -> beat 10 carries 40 (pre-write value); a subsequent dump shows 32'hCAFE. A dump_start pulse mid-dump is ignored.
6. Assert rst_n=0 while dump_idx=17 -> dump_valid and dump_busy drop immediately, no dump_done; after release all registers read 0.

Source files
------------

// File: rtl/regfile_wb_dump.sv
// Register bank with two combinational read ports, gated ALU/load write-back,
// optional write-to-read bypass, and a handshaked engine that streams every register out.
module regfile_wb_dump #(
    parameter int                 XLEN       = 32,
    parameter int                 NREGS      = 32,
    parameter int                 STATE_W    = 4,
    parameter logic [STATE_W-1:0] WB_STATE_A = 4'b0110,
    parameter logic [STATE_W-1:0] WB_STATE_B = 4'b0111,
    parameter int                 BYPASS     = 1,
    localparam int                AW         = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] estado,
    input  logic [AW-1:0]      rs1,
    input  logic [AW-1:0]      rs2,
    input  logic [AW-1:0]      rd,
    input  logic               regiwrite,
    input  logic               memtoreg,
    input  logic [XLEN-1:0]    writedataR,
    input  logic [XLEN-1:0]    reddataM,
    output logic [XLEN-1:0]    readdata1R,
    output logic [XLEN-1:0]    readdata2R,
    input  logic               dump_start,
    input  logic               dump_ready,
    output logic               dump_valid,
    output logic [AW-1:0]      dump_idx,
    output logic [XLEN-1:0]    dump_data,
    output logic               dump_busy,
    output logic               dump_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } dump_state_t;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wb_en;
    logic [XLEN-1:0] wb_data;

    dump_state_t     state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;

    logic [AW-1:0]   rport_idx  [2];
    logic [XLEN-1:0] rport_data [2];

    assign wb_en   = ((estado == WB_STATE_A) || (estado == WB_STATE_B)) && regiwrite && (rd != '0);
    assign wb_data = memtoreg ? reddataM : writedataR;

    // Entry 0 never gets wb_en, so it stays at its reset value of zero.
    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            regs_d[rd] = wb_data;
        end
    end

    assign rport_idx[0] = rs1;
    assign rport_idx[1] = rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            assign rport_data[gi] =
                (rport_idx[gi] == '0)                                  ? '0      :
                ((BYPASS != 0) && wb_en && (rd == rport_idx[gi]))      ? wb_data :
                                                                         regs_q[rport_idx[gi]];
        end
    endgenerate

    assign readdata1R = rport_data[0];
    assign readdata2R = rport_data[1];

    // Dump data is taken from the array without bypass: the beat transferred
    // in a write cycle carries the value from before that write.
    assign dump_data = regs_q[idx_q];
    assign dump_idx  = idx_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                end
            end
            S_SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready) begin
                    if (idx_q == AW'(NREGS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                dump_busy = 1'b1;
                dump_done = 1'b1;
                state_d   = S_IDLE;
                idx_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_dump.sv
// Bench for regfile_wb_dump: bypass and non-bypass instances share stimulus;
// read checks come from a vector table, dump beats from a scoreboard queue.
module tb_regfile_wb_dump;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk;
    logic            rst_n;
    logic [3:0]      estado;
    logic [AW-1:0]   rs1, rs2, rd;
    logic            regiwrite, memtoreg;
    logic [XLEN-1:0] writedataR, reddataM;
    logic            dump_start, dump_ready;

    logic [XLEN-1:0] r1_b, r2_b, r1_n, r2_n, dd_b, dd_n;
    logic            dv_b, dv_n, db_b, db_n, dn_b, dn_n;
    logic [AW-1:0]   di_b, di_n;

    regfile_wb_dump #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .estado(estado), .rs1(rs1), .rs2(rs2), .rd(rd),
        .regiwrite(regiwrite), .memtoreg(memtoreg), .writedataR(writedataR), .reddataM(reddataM),
        .readdata1R(r1_b), .readdata2R(r2_b), .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dv_b), .dump_idx(di_b), .dump_data(dd_b), .dump_busy(db_b), .dump_done(dn_b)
    );

    regfile_wb_dump #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .estado(estado), .rs1(rs1), .rs2(rs2), .rd(rd),
        .regiwrite(regiwrite), .memtoreg(memtoreg), .writedataR(writedataR), .reddataM(reddataM),
        .readdata1R(r1_n), .readdata2R(r2_n), .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dv_n), .dump_idx(di_n), .dump_data(dd_n), .dump_busy(db_n), .dump_done(dn_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  estado;
        logic        we;
        logic        mem;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] wdr;
        logic [31:0] rdm;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] n1;
        logic [31:0] n2;
    } vec_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    vec_t        vecs[10];
    beat_t       sb[$];
    logic [31:0] model[NREGS];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        estado     = 4'h0;
        regiwrite  = 1'b0;
        memtoreg   = 1'b0;
        rd         = '0;
        writedataR = '0;
        reddataM   = '0;
    endtask

    task automatic run_dump(input bit toggle, input bit do_write, input bit mid_start);
        bit    finished;
        beat_t b;
        finished = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            sb.push_back('{5'(i), model[i]});
        end
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
            dump_ready = toggle ? cyc[0] : 1'b1;
            dump_start = mid_start && (cyc == 5);
            if (do_write && dv_b && di_b == 5'd10 && dump_ready) begin
                estado     = 4'b0110;
                regiwrite  = 1'b1;
                memtoreg   = 1'b0;
                rd         = 5'd10;
                writedataR = 32'h0000_CAFE;
                model[10]  = 32'h0000_CAFE;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            if (dv_b && dump_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_beat: got idx %0d expected no more beats", di_b);
                end else begin
                    b = sb.pop_front();
                    check($sformatf("dump_idx[%0d]", b.idx), 32'(di_b), 32'(b.idx));
                    check($sformatf("dump_data[%0d]", b.idx), dd_b, b.data);
                    check($sformatf("dump_data_nb[%0d]", b.idx), dd_n, b.data);
                end
            end
            if (dn_b) begin
                check("done_valid", 32'(dv_b), 32'd0);
                check("done_busy", 32'(db_b), 32'd1);
                check("done_beats_left", 32'(sb.size()), 32'd0);
                if (!toggle) check("done_latency", 32'(cyc), 32'(NREGS + 1));
                dump_start = 1'b0;
                @(posedge clk);
                #1;
                @(negedge clk);
                check("after_done_busy", 32'(db_b), 32'd0);
                check("after_done_pulse", 32'(dn_b), 32'd0);
                finished = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL dump_timeout: got no dump_done expected dump_done within 200 cycles");
        end
        sb.delete();
        dump_ready = 1'b0;
        dump_start = 1'b0;
        idle_inputs();
    endtask

    initial begin
        vecs[0] = '{4'h0, 1'b0, 1'b0, 5'd0,  5'd5,  5'd31, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         32'h0};
        vecs[1] = '{4'h6, 1'b1, 1'b0, 5'd3,  5'd3,  5'd3,  32'hDEADBEEF, 32'h0,         32'hDEADBEEF, 32'hDEADBEEF, 32'h0,         32'h0};
        vecs[2] = '{4'h0, 1'b0, 1'b0, 5'd0,  5'd3,  5'd0,  32'h0,         32'h0,         32'hDEADBEEF, 32'h0,         32'hDEADBEEF, 32'h0};
        vecs[3] = '{4'h7, 1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,         32'h12345678, 32'h0,         32'h0,         32'h0,         32'h0};
        vecs[4] = '{4'h5, 1'b1, 1'b1, 5'd4,  5'd4,  5'd0,  32'h0,         32'h12345678, 32'h0,         32'h0,         32'h0,         32'h0};
        vecs[5] = '{4'h0, 1'b0, 1'b0, 5'd0,  5'd4,  5'd3,  32'h0,         32'h0,         32'h0,         32'hDEADBEEF, 32'h0,         32'hDEADBEEF};
        vecs[6] = '{4'h7, 1'b1, 1'b1, 5'd4,  5'd4,  5'd3,  32'h11111111, 32'h12345678, 32'h12345678, 32'hDEADBEEF, 32'h0,         32'hDEADBEEF};
        vecs[7] = '{4'h6, 1'b0, 1'b0, 5'd4,  5'd4,  5'd4,  32'h22222222, 32'h0,         32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[8] = '{4'h6, 1'b1, 1'b0, 5'd31, 5'd31, 5'd4,  32'hA5A5A5A5, 32'h0,         32'hA5A5A5A5, 32'h12345678, 32'h0,         32'h12345678};
        vecs[9] = '{4'h0, 1'b0, 1'b0, 5'd0,  5'd31, 5'd3,  32'h0,         32'h0,         32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF};
        for (int i = 0; i < NREGS; i++) model[i] = '0;

        rst_n      = 1'b1;
        rs1        = '0;
        rs2        = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        idle_inputs();
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state of the dump side.
        @(negedge clk);
        check("rst_dump_valid", 32'(dv_b), 32'd0);
        check("rst_dump_busy", 32'(db_b), 32'd0);
        check("rst_dump_done", 32'(dn_b), 32'd0);
        check("rst_dump_idx", 32'(di_b), 32'd0);
        step();

        // Read/write-back vectors, evaluated in the same cycle as the stimulus.
        for (int v = 0; v < 10; v++) begin
            estado     = vecs[v].estado;
            regiwrite  = vecs[v].we;
            memtoreg   = vecs[v].mem;
            rd         = vecs[v].rd;
            rs1        = vecs[v].rs1;
            rs2        = vecs[v].rs2;
            writedataR = vecs[v].wdr;
            reddataM   = vecs[v].rdm;
            @(negedge clk);
            check($sformatf("vec%0d_rd1_byp", v), r1_b, vecs[v].e1);
            check($sformatf("vec%0d_rd2_byp", v), r2_b, vecs[v].e2);
            check($sformatf("vec%0d_rd1_nobyp", v), r1_n, vecs[v].n1);
            check($sformatf("vec%0d_rd2_nobyp", v), r2_n, vecs[v].n2);
            step();
        end
        idle_inputs();

        // Preload x1..x31 = index*4, alternating ALU and load sources.
        for (int i = 1; i < NREGS; i++) begin
            estado    = 4'b0110;
            regiwrite = 1'b1;
            rd        = 5'(i);
            memtoreg  = i[0];
            if (i[0]) begin
                reddataM   = 32'(i * 4);
                writedataR = 32'hBAD0_0000 | 32'(i);
            end else begin
                writedataR = 32'(i * 4);
                reddataM   = 32'hBAD1_0000 | 32'(i);
            end
            model[i] = 32'(i * 4);
            step();
        end
        idle_inputs();
        step();

        run_dump(1'b0, 1'b0, 1'b0);
        run_dump(1'b1, 1'b1, 1'b1);
        run_dump(1'b0, 1'b0, 1'b0);

        // Reset in the middle of a dump.
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        repeat (17) step();
        @(negedge clk);
        check("mid_idx_before_rst", 32'(di_b), 32'd17);
        check("mid_valid_before_rst", 32'(dv_b), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(dv_b), 32'd0);
        check("rst_mid_busy", 32'(db_b), 32'd0);
        check("rst_mid_done", 32'(dn_b), 32'd0);
        check("rst_mid_idx", 32'(di_b), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold_done", 32'(dn_b), 32'd0);
        #1 rst_n = 1'b1;
        dump_ready = 1'b0;
        step();
        for (int i = 0; i < NREGS; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(NREGS - 1 - i);
            @(negedge clk);
            check($sformatf("post_rst_x%0d", i), r1_b, 32'h0);
            check($sformatf("post_rst_nb_x%0d", NREGS - 1 - i), r2_n, 32'h0);
            step();
        end
        check("post_rst_done", 32'(dn_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
